io_responder_unit: RTL
======================

IO_RESPONDER_UNIT -- requirements
Module: Io_Responder_Unit

Interface
REQ-001 SHALL have parameter TX_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-002 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_io_en  input  1  memory-stage IO-window select (addr bit 20 and bit 19 set).
REQ-005 SHALL have port i_effective_addr_m  input  32  effective address; only [4:2] decoded.
REQ-006 SHALL have port i_we_m  input  1  word store strobe.
REQ-007 SHALL have port i_re_m  input  1  word load strobe.
REQ-008 SHALL have port i_wdata_m  input  32  store data.
REQ-009 SHALL have port o_rdata_m  output  32  load data, registered.
REQ-010 SHALL have port o_stall_m  output  1  hold memory stage, combinational.
REQ-011 SHALL have port o_tx_valid  output  1  TX byte available.
REQ-012 SHALL have port i_tx_ready  input  1  sink accepts byte.
REQ-013 SHALL have port o_tx_data  output  8  TX byte, FIFO head.
REQ-014 SHALL have port o_irq  output  1  timer interrupt, level.

Function
REQ-015 SHALL act only when i_io_en=1; otherwise i_we_m/i_re_m ignored, o_stall_m=0.
REQ-016 SHALL decode offsets 0x00 TXDATA, 0x04 STATUS, 0x08 TCNT, 0x0C TCMP, 0x10 CTRL; 0x14-0x1C unmapped.
REQ-017 TXDATA write SHALL push i_wdata_m[7:0]; TXDATA read SHALL return 0.
REQ-018 STATUS read SHALL return {25'b0, count[3:0], expired, empty, full} (bit0 full, bit1 empty, bit2 expired, bits[6:3] count).
REQ-019 CTRL bit0 timer_en, bit1 irq_en read/write; writing bit2=1 SHALL clear expired (bit2 reads as expired).
REQ-020 Load SHALL present data on o_rdata_m exactly one cycle after the i_re_m cycle; o_rdata_m SHALL hold value until next load.
REQ-021 Unmapped reads SHALL return 0; unmapped writes SHALL be ignored.
REQ-022 o_stall_m SHALL be 1 while TXDATA write is requested and FIFO full, even if a pop occurs that cycle; no push while stalled.
REQ-023 o_tx_valid = !empty; o_tx_data = head; pop when o_tx_valid & i_tx_ready.
REQ-024 Simultaneous push and pop when non-empty and non-full SHALL leave count unchanged; pointers wrap modulo TX_DEPTH.
REQ-025 When timer_en=1, TCNT SHALL increment each cycle; when TCNT==TCMP it SHALL wrap to 0 next cycle and set expired.
REQ-026 CPU write to TCNT SHALL override increment/wrap in that cycle.
REQ-027 Expired set and CTRL clear in same cycle: set SHALL win.
REQ-028 o_irq = expired & irq_en, registered-free combinational of flops.

Reset
REQ-029 On i_rst_n=0, asynchronously: FIFO empty, pointers 0, TCNT=0, TCMP=0xFFFFFFFF, CTRL=0, expired=0, o_rdata_m=0.
REQ-030 Reset mid-transfer SHALL discard FIFO contents; o_tx_valid=0 immediately.

Configuration
REQ-031 Macro IO_RESPONDER_TIMER_EN defined: timer, TCNT/TCMP, expired, o_irq as specified.
REQ-032 Macro undefined: no timer flops; 0x08/0x0C read 0, writes ignored; expired bit reads 0; o_irq tied 0; CTRL bit0/bit1 read 0.

Structure
REQ-033 Shared package/header Io_Responder_Pkg SHALL hold register offset constants, STATUS bit positions, default TX_DEPTH.
REQ-034 TX FIFO SHALL be sub-module Io_Tx_Fifo (push/pop/full/empty/count, async active-low reset).

Verification
REQ-035 Reset, read STATUS -> o_rdata_m=0x00000002 next cycle; o_tx_valid=0.
REQ-036 i_tx_ready=0, five TXDATA writes 0x41..0x45 -> fifth holds o_stall_m=1; STATUS=0x21; raise ready -> 0x41 popped, stall drops, 0x45 pushed.
REQ-037 TCMP=3, CTRL=0x3 -> TCNT 0,1,2,3,0; expired and o_irq=1 on wrap; CTRL write 0x7 -> o_irq=0 unless wrap same cycle.
REQ-038 Write TCNT=0x10 while counting -> next read 0x10+elapsed, no increment in write cycle.
REQ-039 Write/read offset 0x18 and any access with i_io_en=0 -> no state change, read 0.
REQ-040 Build without IO_RESPONDER_TIMER_EN -> TCNT read 0, o_irq=0 after CTRL=0x3.

Source files
------------

// File: rtl/io_responder_pkg.sv
// Shared constants for the memory-mapped IO responder: register map,
// STATUS/CTRL bit positions and the default TX FIFO depth.
package io_responder_pkg;

  localparam int DEFAULT_TX_DEPTH = 4;

  // Register index = effective address bits [4:2]
  typedef enum logic [2:0] {
    REG_TXDATA = 3'd0,
    REG_STATUS = 3'd1,
    REG_TCNT   = 3'd2,
    REG_TCMP   = 3'd3,
    REG_CTRL   = 3'd4
  } reg_sel_e;

  localparam int STATUS_FULL_BIT    = 0;
  localparam int STATUS_EMPTY_BIT   = 1;
  localparam int STATUS_EXPIRED_BIT = 2;
  localparam int STATUS_COUNT_LSB   = 3;

  localparam int CTRL_TIMER_EN_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int CTRL_CLR_BIT      = 2;

  function automatic logic [31:0] pack_status(input logic [3:0] count,
                                              input logic expired,
                                              input logic empty,
                                              input logic full);
    logic [31:0] v;
    v = '0;
    v[STATUS_FULL_BIT]                          = full;
    v[STATUS_EMPTY_BIT]                         = empty;
    v[STATUS_EXPIRED_BIT]                       = expired;
    v[STATUS_COUNT_LSB+3:STATUS_COUNT_LSB]      = count;
    return v;
  endfunction

endpackage

// File: rtl/io_responder_unit_fifo.sv
// io_tx_fifo: byte FIFO for the TX path; DEPTH must be a power of two so the
// pointers wrap naturally.
module io_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic [7:0]                   i_wdata,
  input  logic                         i_pop,
  output logic [7:0]                   o_rdata,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/io_responder_unit.sv
// Memory-mapped IO responder: TX byte FIFO plus optional compare timer.
// Timer, TCNT/TCMP, expired flag and o_irq exist only with IO_RESPONDER_TIMER_EN.
module io_responder_unit
  import io_responder_pkg::*;
#(
  parameter int TX_DEPTH = DEFAULT_TX_DEPTH
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_io_en,
  input  logic [31:0] i_effective_addr_m,
  input  logic        i_we_m,
  input  logic        i_re_m,
  input  logic [31:0] i_wdata_m,
  output logic [31:0] o_rdata_m,
  output logic        o_stall_m,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_irq
);

  localparam int CW = $clog2(TX_DEPTH) + 1;

  reg_sel_e      w_sel;
  logic          w_wr;
  logic          w_rd;
  logic          w_tx_wr;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_fifo_count;
  logic [4:0]    w_count5;
  logic [31:0]   w_rd_val;
  logic [31:0]   w_tcnt_rd;
  logic [31:0]   w_tcmp_rd;
  logic          w_timer_en_rd;
  logic          w_irq_en_rd;
  logic          w_expired_rd;
  logic [31:0]   r_rdata;
  logic          w_unused;

  assign w_sel    = reg_sel_e'(i_effective_addr_m[4:2]);
  assign w_wr     = i_io_en & i_we_m;
  assign w_rd     = i_io_en & i_re_m;
  assign w_tx_wr  = w_wr & (w_sel == REG_TXDATA);
  assign w_count5 = 5'(w_fifo_count);

  // TX handshake: a byte moves when o_tx_valid && i_tx_ready at a rising edge;
  // o_tx_data is the FIFO head and stays stable until that transfer.
  // A TXDATA store into a full FIFO stalls even if a pop frees a slot that cycle.
  assign o_stall_m  = w_tx_wr & w_full;
  assign o_tx_valid = ~w_empty;

  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_tx_wr & ~w_full),
    .i_wdata (i_wdata_m[7:0]),
    .i_pop   (i_tx_ready),
    .o_rdata (o_tx_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

`ifdef IO_RESPONDER_TIMER_EN
  logic [31:0] r_tcnt;
  logic [31:0] r_tcmp;
  logic        r_timer_en;
  logic        r_irq_en;
  logic        r_expired;
  logic        w_tcnt_wr;
  logic        w_ctrl_wr;
  logic        w_wrap;

  assign w_tcnt_wr = w_wr & (w_sel == REG_TCNT);
  assign w_ctrl_wr = w_wr & (w_sel == REG_CTRL);
  // A CPU write to TCNT pre-empts the wrap, so no expiry is flagged that cycle.
  assign w_wrap    = r_timer_en & (r_tcnt == r_tcmp) & ~w_tcnt_wr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tcnt     <= '0;
      r_tcmp     <= '1;
      r_timer_en <= 1'b0;
      r_irq_en   <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      if (w_tcnt_wr)       r_tcnt <= i_wdata_m;
      else if (w_wrap)     r_tcnt <= '0;
      else if (r_timer_en) r_tcnt <= r_tcnt + 32'd1;
      if (w_wr && (w_sel == REG_TCMP)) r_tcmp <= i_wdata_m;
      if (w_ctrl_wr) begin
        r_timer_en <= i_wdata_m[CTRL_TIMER_EN_BIT];
        r_irq_en   <= i_wdata_m[CTRL_IRQ_EN_BIT];
      end
      if (w_wrap)                                    r_expired <= 1'b1;
      else if (w_ctrl_wr && i_wdata_m[CTRL_CLR_BIT]) r_expired <= 1'b0;
    end
  end

  assign o_irq         = r_expired & r_irq_en;
  assign w_tcnt_rd     = r_tcnt;
  assign w_tcmp_rd     = r_tcmp;
  assign w_timer_en_rd = r_timer_en;
  assign w_irq_en_rd   = r_irq_en;
  assign w_expired_rd  = r_expired;
`else
  assign o_irq         = 1'b0;
  assign w_tcnt_rd     = '0;
  assign w_tcmp_rd     = '0;
  assign w_timer_en_rd = 1'b0;
  assign w_irq_en_rd   = 1'b0;
  assign w_expired_rd  = 1'b0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_sel)
      REG_STATUS: w_rd_val = pack_status(w_count5[3:0], w_expired_rd, w_empty, w_full);
      REG_TCNT:   w_rd_val = w_tcnt_rd;
      REG_TCMP:   w_rd_val = w_tcmp_rd;
      REG_CTRL:   w_rd_val = {29'b0, w_expired_rd, w_irq_en_rd, w_timer_en_rd};
      default:    w_rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_val;
  end

  assign o_rdata_m = r_rdata;

  assign w_unused = ^{i_effective_addr_m[31:5], i_effective_addr_m[1:0],
                      i_wdata_m[31:8], w_count5[4]};

endmodule
